// File: rtl/ofm_ctrl_pkg.sv
// Shared state encoding and default widths for the OFM partial-sum FIFO controller.
package ofm_ctrl_pkg;

  localparam int PIX_W_DEF  = 16;
  localparam int PASS_W_DEF = 8;
  localparam int WR_DLY_DEF = 2;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_FLUSH  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/valid_delay_line.sv
// Delays the accepted-pixel strobe to line up with the adder output; also reports
// whether any write-back is still in flight.
module valid_delay_line #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic in_valid,
  output logic dv,
  output logic any_pending
);

  logic [DEPTH-1:0] stage_reg;
  logic [DEPTH-1:0] stage_next;

  assign stage_next[0] = in_valid;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign stage_next[gi] = stage_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  assign dv          = stage_reg[DEPTH-1];
  assign any_pending = |stage_reg;

endmodule

// File: rtl/ofm_accum_fifo_ctrl.sv
// Pass sequencer for the OFM partial-sum FIFO bank: clears, streams, flushes
// write-backs, and steers the final pass to the output instead of the FIFO.
module ofm_accum_fifo_ctrl
  import ofm_ctrl_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int PASS_W = PASS_W_DEF,
  parameter int WR_DLY = WR_DLY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PIX_W-1:0]  num_pixels,
  input  logic [PASS_W-1:0] num_pass,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              fifo_rd_clr,
  output logic              fifo_wr_clr,
  output logic              fifo_rd_en,
  output logic              fifo_rd_inc,
  output logic              fifo_wr_en,
  output logic              fifo_wr_inc,
  output logic              out_valid,
  output logic [PASS_W-1:0] pass_idx,
  output logic              busy,
  output logic              done,
  output logic              err_ovf
);

  state_t            state_reg, state_next;
  logic [PIX_W-1:0]  npix_reg, npix_next;
  logic [PASS_W-1:0] npass_reg, npass_next;
  logic [PIX_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic [PASS_W-1:0] pass_idx_reg, pass_idx_next;
  logic              err_ovf_reg, err_ovf_next;

  logic              accept;
  logic              start_ok;
  logic              last_pass;
  logic [PIX_W-1:0]  pix_inc;
  logic              dv;
  logic              any_pending;

  assign in_ready  = (state_reg == ST_STREAM);
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (num_pixels != '0) && (num_pass != '0);
  assign last_pass = (pass_idx_reg == (npass_reg - PASS_W'(1)));
  assign pix_inc   = pix_cnt_reg + PIX_W'(1);

  valid_delay_line #(
    .DEPTH(WR_DLY)
  ) u_dly (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state_reg == ST_IDLE),
    .in_valid   (accept),
    .dv         (dv),
    .any_pending(any_pending)
  );

  always_comb begin
    state_next    = state_reg;
    npix_next     = npix_reg;
    npass_next    = npass_reg;
    pix_cnt_next  = pix_cnt_reg;
    pass_idx_next = pass_idx_reg;
    err_ovf_next  = err_ovf_reg;

    if (in_valid && !in_ready && (state_reg != ST_IDLE)) begin
      err_ovf_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start_ok) begin
          state_next    = ST_CLEAR;
          npix_next     = num_pixels;
          npass_next    = num_pass;
          pass_idx_next = '0;
          err_ovf_next  = 1'b0;
        end
      end
      ST_CLEAR: begin
        pix_cnt_next = '0;
        state_next   = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept) begin
          pix_cnt_next = pix_inc;
          if (pix_inc == npix_reg) begin
            state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // Hold the pass boundary until every write-back of this pass has landed.
        if (!any_pending) begin
          if (last_pass) begin
            state_next = ST_DONE;
          end else begin
            pass_idx_next = pass_idx_reg + PASS_W'(1);
            state_next    = ST_CLEAR;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      npix_reg     <= '0;
      npass_reg    <= '0;
      pix_cnt_reg  <= '0;
      pass_idx_reg <= '0;
      err_ovf_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      npix_reg     <= npix_next;
      npass_reg    <= npass_next;
      pix_cnt_reg  <= pix_cnt_next;
      pass_idx_reg <= pass_idx_next;
      err_ovf_reg  <= err_ovf_next;
    end
  end

  assign fifo_rd_clr = (state_reg == ST_CLEAR);
  assign fifo_wr_clr = (state_reg == ST_CLEAR);
  assign fifo_rd_en  = accept && (pass_idx_reg != '0);
  assign fifo_rd_inc = fifo_rd_en;
  assign fifo_wr_en  = dv && !last_pass;
  assign fifo_wr_inc = fifo_wr_en;
  assign out_valid   = dv && last_pass;
  assign pass_idx    = pass_idx_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);
  assign err_ovf     = err_ovf_reg;

endmodule
